// File: rtl/mag_cmp_track_if.sv
// Sample-in / result-out stream bundle for the min/max tracker.
// The DUT takes the slave modport; a producer/consumer model takes master.
interface mag_cmp_track_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 s_vld;
    logic                 s_rdy;
    logic [WIDTH-1:0]     s_val;
    logic                 s_lst;
    logic                 m_vld;
    logic                 m_rdy;
    logic [WIDTH-1:0]     m_max;
    logic [WIDTH-1:0]     m_min;
    logic [CNT_WIDTH-1:0] m_cnt;
    logic                 m_ovf;

    modport master (
        output s_vld, s_val, s_lst, m_rdy,
        input  s_rdy, m_vld, m_max, m_min, m_cnt, m_ovf
    );

    modport slave (
        input  s_vld, s_val, s_lst, m_rdy,
        output s_rdy, m_vld, m_max, m_min, m_cnt, m_ovf
    );
endinterface

// File: rtl/mag_cmp_track.sv
// Streaming per-frame min/max/count tracker built on two unsigned magnitude comparators.
// The result is held in DONE until it is taken; clr aborts the frame synchronously.
module mag_cmp_base #(
    parameter int WIDTH          = 32,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             grt,
    output logic             lst
);
    generate
        if (IMPLEMENTATION == 0) begin : g_direct
            assign grt = (a > b);
            assign lst = (a < b);
        end else begin : g_sub
            // Borrow out of a-b flags a<b; a non-zero difference without borrow flags a>b.
            logic [WIDTH:0] diff;
            assign diff = {1'b0, a} - {1'b0, b};
            assign lst  = diff[WIDTH];
            assign grt  = ~diff[WIDTH] & (|diff[WIDTH-1:0]);
        end
    endgenerate
endmodule

module mag_cmp_track #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    mag_cmp_track_if.slave  s
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state;
    logic [WIDTH-1:0]     max_q;
    logic [WIDTH-1:0]     min_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_q;
    logic                 m_vld_q;
    logic                 s_hs;
    logic                 grt;
    logic                 lst;

    mag_cmp_base #(.WIDTH(WIDTH), .IMPLEMENTATION(0)) u_cmp_max (
        .a   (s.s_val),
        .b   (max_q),
        .grt (grt),
        .lst ()
    );

    mag_cmp_base #(.WIDTH(WIDTH), .IMPLEMENTATION(0)) u_cmp_min (
        .a   (s.s_val),
        .b   (min_q),
        .grt (),
        .lst (lst)
    );

    // Ready depends on state alone, so m_rdy never reaches s_rdy combinationally.
    assign s.s_rdy = (state != DONE);
    assign s_hs    = s.s_vld & s.s_rdy;

    assign s.m_vld = m_vld_q;
    assign s.m_max = max_q;
    assign s.m_min = min_q;
    assign s.m_cnt = cnt_q;
    assign s.m_ovf = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m_vld_q <= 1'b0;
            max_q   <= '0;
            min_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            m_vld_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_hs) begin
                        max_q <= s.s_val;
                        min_q <= s.s_val;
                        cnt_q <= CNT_WIDTH'(1);
                        ovf_q <= 1'b0;
                        if (s.s_lst) begin
                            state   <= DONE;
                            m_vld_q <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (s_hs) begin
                        if (grt) max_q <= s.s_val;
                        if (lst) min_q <= s.s_val;
                        // Count saturates; ovf stays set until the next frame opens.
                        if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
                        else                  cnt_q <= cnt_q + 1'b1;
                        if (s.s_lst) begin
                            state   <= DONE;
                            m_vld_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (s.m_rdy) begin
                        state   <= IDLE;
                        m_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_vld_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mag_cmp_track.sv
// Bench for mag_cmp_track: two instances (16-bit and 2-bit counters) share one stimulus
// stream; a frame model feeds per-instance result queues checked on each result handshake.
module tb_mag_cmp_track;
    localparam int W   = 8;
    localparam int CWA = 16;
    localparam int CWB = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    mag_cmp_track_if #(.WIDTH(W), .CNT_WIDTH(CWA)) ifa ();
    mag_cmp_track_if #(.WIDTH(W), .CNT_WIDTH(CWB)) ifb ();

    mag_cmp_track #(.WIDTH(W), .CNT_WIDTH(CWA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .s     (ifa)
    );

    mag_cmp_track #(.WIDTH(W), .CNT_WIDTH(CWB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .s     (ifb)
    );

    assign ifb.s_vld = ifa.s_vld;
    assign ifb.s_val = ifa.s_val;
    assign ifb.s_lst = ifa.s_lst;
    assign ifb.m_rdy = ifa.m_rdy;

    typedef struct {
        int unsigned mx;
        int unsigned mn;
        int unsigned cnt;
    } res_t;

    res_t qa[$];
    res_t qb[$];

    int n_vec = 0;
    int n_err = 0;

    int unsigned f_mx;
    int unsigned f_mn;
    int unsigned f_cnt;
    bit          f_open = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        res_t r;
        if (rst_n && !clr && ifa.m_vld && ifa.m_rdy) begin
            if (qa.size() == 0) begin
                check("a_unexpected_result", 32'd1, 32'd0);
            end else begin
                r = qa.pop_front();
                check("a_max", ifa.m_max, r.mx);
                check("a_min", ifa.m_min, r.mn);
                check("a_cnt", ifa.m_cnt, (r.cnt > 65535) ? 65535 : r.cnt);
                check("a_ovf", ifa.m_ovf, (r.cnt > 65535) ? 1 : 0);
            end
        end
    end

    always @(negedge clk) begin
        res_t r;
        if (rst_n && !clr && ifb.m_vld && ifb.m_rdy) begin
            if (qb.size() == 0) begin
                check("b_unexpected_result", 32'd1, 32'd0);
            end else begin
                r = qb.pop_front();
                check("b_max", ifb.m_max, r.mx);
                check("b_min", ifb.m_min, r.mn);
                check("b_cnt", ifb.m_cnt, (r.cnt > 3) ? 3 : r.cnt);
                check("b_ovf", ifb.m_ovf, (r.cnt > 3) ? 1 : 0);
            end
        end
    end

    // Offer one sample, wait (bounded) for ready, and update the frame model on acceptance.
    task automatic push(input logic [7:0] v, input bit l);
        int   k;
        res_t r;
        k = 0;
        ifa.s_vld = 1'b1;
        ifa.s_val = v;
        ifa.s_lst = l;
        @(negedge clk);
        while (!ifa.s_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ifa.s_rdy) check("push_timeout", {31'd0, ifa.s_rdy}, 32'd1);
        @(posedge clk);
        #1;
        ifa.s_vld = 1'b0;
        ifa.s_lst = 1'b0;
        if (!f_open) begin
            f_mx   = v;
            f_mn   = v;
            f_cnt  = 1;
            f_open = 1'b1;
        end else begin
            if (v > f_mx) f_mx = v;
            if (v < f_mn) f_mn = v;
            f_cnt++;
        end
        if (l) begin
            r.mx  = f_mx;
            r.mn  = f_mn;
            r.cnt = f_cnt;
            qa.push_back(r);
            qb.push_back(r);
            f_open = 1'b0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.s_vld = 1'b0;
        ifa.s_val = '0;
        ifa.s_lst = 1'b0;
        ifa.m_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mvld", ifa.m_vld, 0);
        check("rst_srdy", ifa.s_rdy, 1);
        check("rst_max",  ifa.m_max, 0);
        check("rst_min",  ifa.m_min, 0);
        check("rst_cnt",  ifa.m_cnt, 0);
        check("rst_ovf",  ifa.m_ovf, 0);
        rst_n = 1'b1;
        next_cycle();

        // Basic frame: result one cycle after the last sample.
        push(8'd5, 0);
        push(8'd3, 0);
        push(8'd9, 0);
        push(8'd9, 0);
        push(8'd1, 1);
        check("t1_mvld", ifa.m_vld, 1);
        check("t1_srdy", ifa.s_rdy, 0);
        check("t1_max",  ifa.m_max, 9);
        check("t1_min",  ifa.m_min, 1);
        check("t1_cnt",  ifa.m_cnt, 5);
        check("t1_ovf",  ifa.m_ovf, 0);
        next_cycle();

        // Single-sample frame.
        push(8'hFF, 1);
        check("t2_mvld", ifa.m_vld, 1);
        check("t2_srdy", ifa.s_rdy, 0);
        check("t2_max",  ifa.m_max, 8'hFF);
        check("t2_min",  ifa.m_min, 8'hFF);
        check("t2_cnt",  ifa.m_cnt, 1);
        next_cycle();

        // Back-pressure on the result with the next sample already offered.
        ifa.m_rdy = 1'b0;
        push(8'd10, 0);
        push(8'd20, 1);
        ifa.s_vld = 1'b1;
        ifa.s_val = 8'h42;
        ifa.s_lst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t3_mvld", ifa.m_vld, 1);
            check("t3_srdy", ifa.s_rdy, 0);
            check("t3_max",  ifa.m_max, 20);
            check("t3_min",  ifa.m_min, 10);
            check("t3_cnt",  ifa.m_cnt, 2);
        end
        ifa.m_rdy = 1'b1;
        push(8'h42, 1);
        check("t3_next_max", ifa.m_max, 8'h42);
        check("t3_next_cnt", ifa.m_cnt, 1);
        next_cycle();

        // Counter saturation on the 2-bit instance, then ovf clears on the next frame.
        push(8'd1, 0);
        push(8'd2, 0);
        push(8'd3, 0);
        push(8'd4, 0);
        push(8'd5, 1);
        check("t4_b_cnt", ifb.m_cnt, 3);
        check("t4_b_ovf", ifb.m_ovf, 1);
        check("t4_a_cnt", ifa.m_cnt, 5);
        next_cycle();
        push(8'd7, 0);
        push(8'd8, 1);
        check("t4_b_cnt2", ifb.m_cnt, 2);
        check("t4_b_ovf2", ifb.m_ovf, 0);
        next_cycle();

        // Synchronous abort mid-frame drops the offered sample and the partial frame.
        push(8'd2, 0);
        push(8'd7, 0);
        ifa.s_vld = 1'b1;
        ifa.s_val = 8'd9;
        ifa.s_lst = 1'b0;
        clr       = 1'b1;
        next_cycle();
        clr       = 1'b0;
        ifa.s_vld = 1'b0;
        f_open    = 1'b0;
        check("t5_mvld", ifa.m_vld, 0);
        check("t5_srdy", ifa.s_rdy, 1);
        check("t5_cnt",  ifa.m_cnt, 0);
        push(8'd4, 0);
        push(8'd6, 1);
        check("t5_max", ifa.m_max, 6);
        check("t5_min", ifa.m_min, 4);
        check("t5_cnt2", ifa.m_cnt, 2);
        next_cycle();

        // Asynchronous reset while a result is being held.
        ifa.m_rdy = 1'b0;
        push(8'd3, 0);
        push(8'd1, 1);
        check("t6_pre_mvld", ifa.m_vld, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_mvld",   ifa.m_vld, 0);
        check("t6_srdy",   ifa.s_rdy, 1);
        check("t6_max",    ifa.m_max, 0);
        check("t6_min",    ifa.m_min, 0);
        check("t6_cnt",    ifa.m_cnt, 0);
        check("t6_ovf",    ifa.m_ovf, 0);
        check("t6_b_cnt",  ifb.m_cnt, 0);
        qa.delete();
        qb.delete();
        ifa.m_rdy = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        push(8'd8, 1);
        check("t6_recover_max", ifa.m_max, 8);

        repeat (3) @(posedge clk);
        #1;
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
